// File: rtl/alu_op_issuer.sv
// ---------------------------------------------------------------------------
// alu_op_issuer
//
// Sequential initiator for an external combinational ALU datapath
// (AND / OR / XOR / adder behind a result mux). It accepts one operation per
// req_valid/req_ready handshake, drives the datapath, captures the result and
// returns it with flags over a rsp_valid/rsp_ready channel.
//   SUB  : adder with inverted B and carry-in 1 (carry 1 = no borrow)
//   SLT  : SUB drive, signed less-than from sign bit and overflow
//   MUL  : iterative shift-add loop on the adder, low WIDTH bits kept
//
// Optional feature: define MUL_EARLY_EXIT_EN to leave the MUL loop as soon as
// the remaining multiplier is zero (same results, shorter latency).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/ready/op/a/b   request channel
//   alu_a/b/cin/sel          datapath drive (registered)
//   alu_y, alu_cout          datapath result, combinational from alu_*
//   rsp_valid/ready          response handshake
//   rsp_result/carry/zero/err response payload
//   busy                     issuer is not idle
// ---------------------------------------------------------------------------
module alu_op_issuer #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] ERR_RESULT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_XOR = 3'b011;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;
    typedef enum logic [2:0] {
        OP_AND = 3'b000, OP_OR  = 3'b001, OP_ADD = 3'b010, OP_XOR = 3'b011,
        OP_SUB = 3'b100, OP_SLT = 3'b101, OP_MUL = 3'b110, OP_ILL = 3'b111
    } op_t;

    state_t             r_state;
    op_t                r_op;
    logic [WIDTH-1:0]   r_a;          // operand A; multiplicand during MUL
    logic [WIDTH-1:0]   r_b;          // operand B; multiplier during MUL
    logic [CNT_W-1:0]   r_cnt;
    logic               r_req_ready;
    logic               r_busy;
    logic [WIDTH-1:0]   r_alu_a;      // also the MUL accumulator
    logic [WIDTH-1:0]   r_alu_b;
    logic               r_alu_cin;
    logic [2:0]         r_alu_sel;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_result;
    logic               r_rsp_carry;
    logic               r_rsp_zero;
    logic               r_rsp_err;

    op_t                w_req_op;
    logic               w_req_sub;
    logic [2:0]         w_req_sel;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_exec_result;
    logic               w_exec_carry;
    logic [WIDTH-1:0]   w_mcand_nxt;
    logic [WIDTH-1:0]   w_mplier_nxt;
    logic               w_mul_done;

    assign w_req_op     = op_t'(req_op);
    assign w_req_sub    = (w_req_op == OP_SUB) || (w_req_op == OP_SLT);
    assign w_mcand_nxt  = r_a << 1;
    assign w_mplier_nxt = r_b >> 1;

`ifdef MUL_EARLY_EXIT_EN
    // Once the remaining multiplier is zero no further step can change acc.
    assign w_mul_done = (w_mplier_nxt == '0) || (r_cnt == LAST_STEP);
`else
    assign w_mul_done = (r_cnt == LAST_STEP);
`endif

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_req_sel = SEL_ADD;
        case (w_req_op)
            OP_AND:  w_req_sel = SEL_AND;
            OP_OR:   w_req_sel = SEL_OR;
            OP_XOR:  w_req_sel = SEL_XOR;
            default: w_req_sel = SEL_ADD;
        endcase
    end

    // EXEC result shaping. SLT: signed a < b is sign(a-b) corrected by overflow.
    always_comb begin
        w_ovf         = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_a[WIDTH-1] ^ alu_y[WIDTH-1]);
        w_exec_result = alu_y;
        w_exec_carry  = 1'b0;
        case (r_op)
            OP_ADD, OP_SUB: w_exec_carry  = alu_cout;
            OP_SLT:         w_exec_result = {{(WIDTH-1){1'b0}}, alu_y[WIDTH-1] ^ w_ovf};
            default:        ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= OP_AND;
            r_a          <= '0;
            r_b          <= '0;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_cin    <= 1'b0;
            r_alu_sel    <= SEL_AND;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op        <= w_req_op;
                        r_a         <= req_a;
                        r_b         <= req_b;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        case (w_req_op)
                            OP_MUL: begin
                                // First step's drive: acc = 0, add a if b[0].
                                r_state   <= S_MUL;
                                r_alu_a   <= '0;
                                r_alu_b   <= req_b[0] ? req_a : '0;
                                r_alu_cin <= 1'b0;
                                r_alu_sel <= SEL_ADD;
                            end
                            OP_ILL: begin
                                r_state      <= S_RESP;
                                r_rsp_valid  <= 1'b1;
                                r_rsp_result <= ERR_RESULT;
                                r_rsp_carry  <= 1'b0;
                                r_rsp_zero   <= (ERR_RESULT == '0);
                                r_rsp_err    <= 1'b1;
                            end
                            default: begin
                                r_state   <= S_EXEC;
                                r_alu_a   <= req_a;
                                r_alu_b   <= w_req_sub ? ~req_b : req_b;
                                r_alu_cin <= w_req_sub;
                                r_alu_sel <= w_req_sel;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    r_state      <= S_RESP;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_result <= w_exec_result;
                    r_rsp_carry  <= w_exec_carry;
                    r_rsp_zero   <= (w_exec_result == '0);
                    r_rsp_err    <= 1'b0;
                    r_alu_a      <= '0;
                    r_alu_b      <= '0;
                    r_alu_cin    <= 1'b0;
                    r_alu_sel    <= SEL_AND;
                end
                S_MUL: begin
                    r_a   <= w_mcand_nxt;
                    r_b   <= w_mplier_nxt;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_mul_done) begin
                        r_state      <= S_RESP;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_result <= alu_y;
                        r_rsp_carry  <= 1'b0;
                        r_rsp_zero   <= (alu_y == '0);
                        r_rsp_err    <= 1'b0;
                        r_alu_a      <= '0;
                        r_alu_b      <= '0;
                        r_alu_sel    <= SEL_AND;
                    end else begin
                        // Next step's drive from the shifted operands.
                        r_alu_a <= alu_y;
                        r_alu_b <= w_mplier_nxt[0] ? w_mcand_nxt : '0;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign busy       = r_busy;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_cin    = r_alu_cin;
    assign alu_sel    = r_alu_sel;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_carry  = r_rsp_carry;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;

endmodule
